step_dir_gen: RTL

- Stepper step/dir pulse generator that consumes the clock-enable tick from the variable clock divider.
- Executes one motion segment per command: N steps, fixed tick period, given direction.
- Emits STEP/DIR to the motor driver with driver-safe pulse width and DIR setup time.
- Tracks signed absolute position for readback over the host bus.

---
 rtl/step_dir_if.sv | 15 +
 rtl/step_dir_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/step_dir_if.sv
// Command channel of the step/dir generator: one motion segment per transfer.
// A transfer happens on a cycle where cmd_valid && cmd_ready.
interface step_dir_if #(
    parameter int STEPS_W = 32,
    parameter int PER_W   = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;
    logic [PER_W-1:0]   cmd_period;

    modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_dir_gen.sv
// Stepper STEP/DIR pulse generator: runs N steps per command at a tick-based period,
// honours DIR setup time and minimum pulse width, and tracks signed position.
module step_dir_gen #(
    parameter int STEPS_W = 32,
    parameter int PER_W   = 16,
    parameter int POS_W   = 32
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             tick,
    step_dir_if.slave        cmd,
    input  logic [PER_W-1:0] pulse_width,
    input  logic [PER_W-1:0] dir_setup,
    input  logic             abort,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_in,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    state_t             r_state, w_state_nxt;
    logic [PER_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PER_W-1:0]   r_pw, w_pw_nxt;
    logic [PER_W-1:0]   r_low, w_low_nxt;
    logic [PER_W-1:0]   r_setup, w_setup_nxt;
    logic [STEPS_W-1:0] r_rem, w_rem_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt;
    logic               r_step, w_step_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_done, w_done_nxt;
    logic               r_aborted, w_aborted_nxt;
    logic               r_abort_lat, w_abort_lat_nxt;
    logic               r_ready_en;

    logic               w_idle, w_accept;
    logic [PER_W-1:0]   w_pw_eff, w_low_eff;
    logic [PER_W:0]     w_low_diff;
    logic [POS_W-1:0]   w_pos_base;
    logic [STEPS_W-1:0] w_rem_base;
    logic               w_go_high, w_go_idle, w_go_abort;

    assign w_idle        = (r_state == S_IDLE);
    assign cmd.cmd_ready = r_ready_en && w_idle && !abort;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

    // LOW time is period minus effective pulse width, clamped to one tick when not positive.
    assign w_pw_eff   = (pulse_width == '0) ? PER_W'(1) : pulse_width;
    assign w_low_diff = {1'b0, cmd.cmd_period} - {1'b0, w_pw_eff};
    assign w_low_eff  = (w_low_diff[PER_W] || (w_low_diff == '0)) ? PER_W'(1)
                                                                  : w_low_diff[PER_W-1:0];

    // A load coinciding with accept is the base the first step counts from.
    assign w_pos_base = (w_idle && pos_load) ? pos_in : r_pos;
    assign w_rem_base = w_idle ? cmd.cmd_steps : r_rem;

    always_comb begin
        // NOTE: every next-value gets a default first, so no branch can infer a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = tick ? r_cnt + 1'b1 : r_cnt;
        w_pw_nxt        = r_pw;
        w_low_nxt       = r_low;
        w_setup_nxt     = r_setup;
        w_rem_nxt       = r_rem;
        w_pos_nxt       = r_pos;
        w_step_nxt      = r_step;
        w_dir_nxt       = r_dir;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_abort_lat_nxt = r_abort_lat;
        w_go_high       = 1'b0;
        w_go_idle       = 1'b0;
        w_go_abort      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (pos_load) w_pos_nxt = pos_in;
                if (w_accept) begin
                    w_pw_nxt        = w_pw_eff;
                    w_low_nxt       = w_low_eff;
                    w_setup_nxt     = dir_setup;
                    w_abort_lat_nxt = 1'b0;
                    if (cmd.cmd_steps == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (cmd.cmd_dir != r_dir) begin
                        w_dir_nxt   = cmd.cmd_dir;
                        w_rem_nxt   = cmd.cmd_steps;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_go_high = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_go_idle  = 1'b1;
                    w_go_abort = 1'b1;
                end else if ((r_setup == '0) || (tick && (r_cnt == r_setup - 1'b1))) begin
                    w_go_high = 1'b1;
                end
            end
            S_HIGH: begin
                // Abort during the pulse is held until the full width elapses.
                if (abort) w_abort_lat_nxt = 1'b1;
                if (tick && (r_cnt == r_pw - 1'b1)) begin
                    w_step_nxt = 1'b0;
                    if (r_abort_lat || abort) begin
                        w_go_idle  = 1'b1;
                        w_go_abort = 1'b1;
                    end else begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_LOW: begin
                if (abort) begin
                    w_go_idle  = 1'b1;
                    w_go_abort = 1'b1;
                end else if (tick && (r_cnt == r_low - 1'b1)) begin
                    if (r_rem == '0) w_go_idle = 1'b1;
                    else             w_go_high = 1'b1;
                end
            end
        endcase

        if (w_go_high) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
            w_rem_nxt   = w_rem_base - 1'b1;
            w_pos_nxt   = r_dir ? w_pos_base + 1'b1 : w_pos_base - 1'b1;
        end
        if (w_go_idle) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_step_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_aborted_nxt   = w_go_abort;
            w_abort_lat_nxt = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pw        <= '0;
            r_low       <= '0;
            r_setup     <= '0;
            r_rem       <= '0;
            r_pos       <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_abort_lat <= 1'b0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pw        <= w_pw_nxt;
            r_low       <= w_low_nxt;
            r_setup     <= w_setup_nxt;
            r_rem       <= w_rem_nxt;
            r_pos       <= w_pos_nxt;
            r_step      <= w_step_nxt;
            r_dir       <= w_dir_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_abort_lat <= w_abort_lat_nxt;
            r_ready_en  <= 1'b1;
        end
    end

    assign step    = r_step;
    assign dir     = r_dir;
    assign busy    = !w_idle;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign pos     = r_pos;

endmodule
